// File: rtl/seq_restoring_div_pkg.sv
// Shared state encoding and sizing helpers for the sequential restoring divider.
// Imported by seq_restoring_div (optional signed mode: DIV_SIGNED_EN).
package seq_restoring_div_pkg;

    localparam int DIV_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_run  = 2'd1,
        st_done = 2'd2
    } div_state_e;

    // Iteration counter must be able to hold the value WIDTH.
    function automatic int div_count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_restoring_div_if.sv
// Start/done handshake and operand/result bundle between a controller (master)
// and the divider (slave).
interface seq_restoring_div_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the ripple adder/subtractor datapaths.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/ripple_sub_stage.sv
// Combinational N-bit ripple subtractor: diff = a + ~b + 1, borrow = ~carry_out.
module ripple_sub_stage #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    logic [N:0] carry;

    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            full_adder u_fa (
                .a    (a[gi]),
                .b    (~b[gi]),
                .cin  (carry[gi]),
                .s    (diff[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    assign borrow = ~carry[N];
endmodule

// File: rtl/seq_restoring_div.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (sign fix-up around the unsigned core).
module seq_restoring_div
    import seq_restoring_div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input logic                clk,
    input logic                rst_n,
    seq_restoring_div_if.slave bus
);
    localparam int CW = div_count_width(WIDTH);

    div_state_e       state_reg, state_next;
    logic [WIDTH:0]   r_reg, r_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] quot_reg, quot_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic             dbz_reg, dbz_next;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   t_diff;
    logic             t_borrow;
    logic [WIDTH-1:0] load_dividend;
    logic [WIDTH-1:0] load_divisor;

`ifdef DIV_SIGNED_EN
    logic neg_q_reg, neg_q_next;
    logic neg_r_reg, neg_r_next;

    assign load_dividend = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign load_divisor  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
`else
    assign load_dividend = bus.dividend;
    assign load_divisor  = bus.divisor;
`endif

    // R' = {R[WIDTH-1:0], Q[msb]}; R's top bit is always 0 between iterations.
    assign r_shift = (r_reg << 1) | (WIDTH+1)'(q_reg[WIDTH-1]);

    ripple_sub_stage #(.N(WIDTH + 1)) u_sub (
        .a      (r_shift),
        .b      ({1'b0, d_reg}),
        .diff   (t_diff),
        .borrow (t_borrow)
    );

    always_comb begin
        state_next = state_reg;
        r_next     = r_reg;
        q_next     = q_reg;
        d_next     = d_reg;
        count_next = count_reg;
        quot_next  = quot_reg;
        rem_next   = rem_reg;
        dbz_next   = dbz_reg;
`ifdef DIV_SIGNED_EN
        neg_q_next = neg_q_reg;
        neg_r_next = neg_r_reg;
`endif
        case (state_reg)
            st_idle: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        state_next = st_done;
                        quot_next  = '1;
                        rem_next   = bus.dividend;
                        dbz_next   = 1'b1;
                    end else begin
                        state_next = st_run;
                        r_next     = '0;
                        q_next     = load_dividend;
                        d_next     = load_divisor;
                        count_next = '0;
                        dbz_next   = 1'b0;
`ifdef DIV_SIGNED_EN
                        neg_q_next = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        neg_r_next = bus.dividend[WIDTH-1];
`endif
                    end
                end
            end
            st_run: begin
                // Within this operand range the borrow equals T's sign bit.
                if (t_borrow) begin
                    r_next = r_shift;
                    q_next = {q_reg[WIDTH-2:0], 1'b0};
                end else begin
                    r_next = t_diff;
                    q_next = {q_reg[WIDTH-2:0], 1'b1};
                end
                count_next = count_reg + CW'(1);
                if (count_reg == CW'(WIDTH - 1)) begin
                    state_next = st_done;
`ifdef DIV_SIGNED_EN
                    quot_next = neg_q_reg ? -q_next : q_next;
                    rem_next  = neg_r_reg ? -r_next[WIDTH-1:0] : r_next[WIDTH-1:0];
`else
                    quot_next = q_next;
                    rem_next  = r_next[WIDTH-1:0];
`endif
                end
            end
            st_done: begin
                state_next = st_idle;
            end
            default: begin
                state_next = st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= st_idle;
            r_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            count_reg <= '0;
            quot_reg  <= '0;
            rem_reg   <= '0;
            dbz_reg   <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            r_reg     <= r_next;
            q_reg     <= q_next;
            d_reg     <= d_next;
            count_reg <= count_next;
            quot_reg  <= quot_next;
            rem_reg   <= rem_next;
            dbz_reg   <= dbz_next;
`ifdef DIV_SIGNED_EN
            neg_q_reg <= neg_q_next;
            neg_r_reg <= neg_r_next;
`endif
        end
    end

    assign bus.busy        = (state_reg == st_run);
    assign bus.done        = (state_reg == st_done);
    assign bus.quotient    = quot_reg;
    assign bus.remainder   = rem_reg;
    assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_restoring_div.sv
// Self-checking bench for seq_restoring_div (WIDTH=4): constant vectors, exhaustive
// sweep and random operations against an arithmetic model, plus handshake corner cases.
module tb_seq_restoring_div;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_restoring_div_if #(.WIDTH(W)) bus_if ();

    seq_restoring_div #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division with the divide-by-zero convention.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            int sa;
            int sb;
            sa = $signed(a);
            sb = $signed(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
`else
            q  = W'(int'(a) / int'(b));
            r  = W'(int'(a) % int'(b));
`endif
            dz = 1'b0;
        end
    endtask

    // One full transaction from IDLE; operand inputs are scrambled after acceptance.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                          output int lat, output bit busy_ok, output bit pulse_ok);
        bus_if.start    = 1'b1;
        bus_if.dividend = a;
        bus_if.divisor  = b;
        step();
        bus_if.start = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!bus_if.done && lat < 20) begin
            if (!bus_if.busy) busy_ok = 1'b0;
            bus_if.dividend = W'($urandom);
            bus_if.divisor  = W'($urandom);
            step();
            lat++;
        end
        if (bus_if.busy) busy_ok = 1'b0;
        q  = bus_if.quotient;
        r  = bus_if.remainder;
        dz = bus_if.div_by_zero;
        step();
        pulse_ok = !bus_if.done && !bus_if.busy;
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
        bit           busy_ok;
        bit           pulse_ok;
        run_op(a, b, q, r, dz, lat, busy_ok, pulse_ok);
        $display("%s: %0d / %0d -> q=%0d r=%0d dz=%0d lat=%0d", tag, a, b, q, r, dz, lat);
        check({tag, " quotient"}, 32'(q), 32'(eq));
        check({tag, " remainder"}, 32'(r), 32'(er));
        check({tag, " div_by_zero"}, 32'(dz), 32'(edz));
        check({tag, " latency"}, lat, (b == 0) ? 0 : W);
        check({tag, " busy pattern"}, 32'(busy_ok), 32'd1);
        check({tag, " done pulse"}, 32'(pulse_ok), 32'd1);
    endtask

    initial begin
        vec_t         vecs[$];
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        bit           saw_done;
        int           n;

        checks = 0;
        errors = 0;
`ifdef DIV_SIGNED_EN
        vecs.push_back(vec_t'{4'b1001, 4'd2,    4'b1101, 4'b1111, 1'b0}); // -7/2
        vecs.push_back(vec_t'{4'b1000, 4'b1111, 4'b1000, 4'd0,    1'b0}); // -8/-1
        vecs.push_back(vec_t'{4'd7,    4'b1110, 4'b1101, 4'd1,    1'b0}); // 7/-2
        vecs.push_back(vec_t'{4'b1010, 4'b1101, 4'd2,    4'd0,    1'b0}); // -6/-3
        vecs.push_back(vec_t'{4'b1101, 4'd7,    4'd0,    4'b1101, 1'b0}); // -3/7
        vecs.push_back(vec_t'{4'd3,    4'd7,    4'd0,    4'd3,    1'b0});
        vecs.push_back(vec_t'{4'd5,    4'd0,    4'hF,    4'd5,    1'b1});
        vecs.push_back(vec_t'{4'hF,    4'd0,    4'hF,    4'hF,    1'b1});
`else
        vecs.push_back(vec_t'{4'd13, 4'd3,  4'd4,  4'd1, 1'b0});
        vecs.push_back(vec_t'{4'd15, 4'd15, 4'd1,  4'd0, 1'b0});
        vecs.push_back(vec_t'{4'd3,  4'd7,  4'd0,  4'd3, 1'b0});
        vecs.push_back(vec_t'{4'd5,  4'd0,  4'd15, 4'd5, 1'b1});
        vecs.push_back(vec_t'{4'd9,  4'd2,  4'd4,  4'd1, 1'b0});
        vecs.push_back(vec_t'{4'd14, 4'd7,  4'd2,  4'd0, 1'b0});
        vecs.push_back(vec_t'{4'd11, 4'd3,  4'd3,  4'd2, 1'b0});
        vecs.push_back(vec_t'{4'd15, 4'd1,  4'd15, 4'd0, 1'b0});
        vecs.push_back(vec_t'{4'd8,  4'd9,  4'd0,  4'd8, 1'b0});
        vecs.push_back(vec_t'{4'd0,  4'd5,  4'd0,  4'd0, 1'b0});
`endif

        rst_n           = 1'b0;
        bus_if.start    = 1'b0;
        bus_if.dividend = '0;
        bus_if.divisor  = '0;
        repeat (2) step();
        check("reset busy", 32'(bus_if.busy), 32'd0);
        check("reset done", 32'(bus_if.done), 32'd0);
        check("reset quotient", 32'(bus_if.quotient), 32'd0);
        check("reset remainder", 32'(bus_if.remainder), 32'd0);
        check("reset div_by_zero", 32'(bus_if.div_by_zero), 32'd0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            do_op("vec", vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
        end

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                a = W'(ia);
                b = W'(ib);
                ref_div(a, b, eq, er, edz);
                do_op("sweep", a, b, eq, er, edz);
            end
        end

        for (int k = 0; k < 60; k++) begin
            a = W'($urandom_range(0, 15));
            b = W'($urandom_range(0, 15));
            ref_div(a, b, eq, er, edz);
            do_op("rand", a, b, eq, er, edz);
        end

        // Start requests during RUN and DONE must be dropped, not queued.
        bus_if.start    = 1'b1;
        bus_if.dividend = 4'd9;
        bus_if.divisor  = 4'd2;
        step();                                 // edge k: accept 9/2
        bus_if.start = 1'b0;
        step();                                 // k+1
        bus_if.start    = 1'b1;
        bus_if.dividend = 4'd14;
        bus_if.divisor  = 4'd7;
        step();                                 // k+2: ignored
        bus_if.start = 1'b0;
        check("ignore busy k+2", 32'(bus_if.busy), 32'd1);
        step();                                 // k+3
        check("ignore not done k+3", 32'(bus_if.done), 32'd0);
        step();                                 // k+4: finish
        ref_div(4'd9, 4'd2, eq, er, edz);
        check("ignore done k+4", 32'(bus_if.done), 32'd1);
        check("ignore quotient", 32'(bus_if.quotient), 32'(eq));
        check("ignore remainder", 32'(bus_if.remainder), 32'(er));
        $display("ignore: 9 / 2 -> q=%0d r=%0d", bus_if.quotient, bus_if.remainder);
        bus_if.start = 1'b1;
        step();                                 // k+5: in DONE, ignored
        check("ignore done k+5", 32'(bus_if.done), 32'd0);
        check("ignore idle k+5", 32'(bus_if.busy), 32'd0);
        step();                                 // k+6: accepted
        bus_if.start = 1'b0;
        check("restart busy k+6", 32'(bus_if.busy), 32'd1);
        n = 0;
        while (!bus_if.done && n < 20) begin
            step();
            n++;
        end
        ref_div(4'd14, 4'd7, eq, er, edz);
        check("restart latency", n, W);
        check("restart quotient", 32'(bus_if.quotient), 32'(eq));
        check("restart remainder", 32'(bus_if.remainder), 32'(er));
        $display("restart: 14 / 7 -> q=%0d r=%0d", bus_if.quotient, bus_if.remainder);
        step();

        // Asynchronous reset in the middle of RUN.
        bus_if.start    = 1'b1;
        bus_if.dividend = 4'd11;
        bus_if.divisor  = 4'd3;
        step();                                 // edge k
        bus_if.start = 1'b0;
        step();                                 // k+1
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(bus_if.busy), 32'd0);
        check("abort done", 32'(bus_if.done), 32'd0);
        check("abort quotient", 32'(bus_if.quotient), 32'd0);
        check("abort remainder", 32'(bus_if.remainder), 32'd0);
        check("abort div_by_zero", 32'(bus_if.div_by_zero), 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            step();
            if (bus_if.done || bus_if.busy) saw_done = 1'b1;
        end
        check("abort no activity", 32'(saw_done), 32'd0);
        $display("abort: 11 / 3 reset during RUN");
        rst_n = 1'b1;
        step();
        ref_div(4'd11, 4'd3, eq, er, edz);
        do_op("after reset", 4'd11, 4'd3, eq, er, edz);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
